// File: rtl/serial_pkg.sv
// Shared definitions for the serial deserializer: FSM encoding, default width, start-bit value.
// The PARITY state exists only when PARITY_CHECK_EN is defined.
package serial_pkg;

  localparam int DEFAULT_WIDTH = 4;
  localparam logic START_BIT = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1
`ifdef PARITY_CHECK_EN
    ,
    PARITY = 2'd2
`endif
  } state_t;

endpackage

// File: rtl/serial_deserializer_if.sv
// Serial input / parallel valid-ready output bundle of the deserializer.
// The slave modport is the deserializer side, master is the driving/consuming side.
interface serial_deserializer_if
  import serial_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             bit_in;
  logic             bit_valid;
  logic             out_ready;
  logic             overrun_clr;
  logic [WIDTH-1:0] word_out;
  logic             word_valid;
  logic             overrun;
  logic             parity_err;

  modport master (
    output bit_in, bit_valid, out_ready, overrun_clr,
    input  word_out, word_valid, overrun, parity_err
  );

  modport slave (
    input  bit_in, bit_valid, out_ready, overrun_clr,
    output word_out, word_valid, overrun, parity_err
  );

endinterface

// File: rtl/deser_bit_counter.sv
// Data-bit counter for the deserializer: enable, synchronous load-zero, and a flag on the
// final data bit of a frame.
module deser_bit_counter
  import serial_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic clock,
  input  logic clear,
  input  logic enable,
  input  logic load_zero,
  output logic last_data
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [CW-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop updates from pre-edge values.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      count <= '0;
    end else if (load_zero) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CW'(1);
    end
  end

  assign last_data = (count == CW'(WIDTH - 1));

endmodule

// File: rtl/serial_deserializer.sv
// Serial-to-parallel deserializer: start-bit detect, MSB-first assembly, one-word output buffer
// with overrun flag. Optional even-parity check is enabled by defining PARITY_CHECK_EN.
module serial_deserializer
  import serial_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                  clock,
  input  logic                  clear,
  serial_deserializer_if.slave  bus
);

  state_t           state, state_next;
  logic [WIDTH-1:0] sh, sh_next;
  logic             cnt_en, cnt_zero, last_data;
  logic             complete;
  logic [WIDTH-1:0] complete_word;
  logic [WIDTH-1:0] word_q;
  logic             valid_q, overrun_q;
  logic             accept, drop;
`ifdef PARITY_CHECK_EN
  logic             complete_perr;
  logic             perr_q;
`endif

  deser_bit_counter #(.WIDTH(WIDTH)) u_counter (
    .clock    (clock),
    .clear    (clear),
    .enable   (cnt_en),
    .load_zero(cnt_zero),
    .last_data(last_data)
  );

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state <= IDLE;
      sh    <= '0;
    end else begin
      state <= state_next;
      sh    <= sh_next;
    end
  end

  // NOTE: every output gets a default first so no path through the case leaves a latch.
  always_comb begin
    state_next    = state;
    sh_next       = sh;
    cnt_en        = 1'b0;
    cnt_zero      = 1'b0;
    complete      = 1'b0;
    complete_word = sh;
`ifdef PARITY_CHECK_EN
    complete_perr = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (bus.bit_valid && bus.bit_in == START_BIT) begin
          state_next = DATA;
          cnt_zero   = 1'b1;
        end
      end
      DATA: begin
        if (bus.bit_valid) begin
          sh_next = {sh[WIDTH-2:0], bus.bit_in};
          cnt_en  = 1'b1;
          if (last_data) begin
`ifdef PARITY_CHECK_EN
            state_next = PARITY;
`else
            state_next    = IDLE;
            complete      = 1'b1;
            complete_word = sh_next;
`endif
          end
        end
      end
`ifdef PARITY_CHECK_EN
      PARITY: begin
        if (bus.bit_valid) begin
          state_next    = IDLE;
          complete      = 1'b1;
          complete_perr = ^{sh, bus.bit_in};
        end
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  // A finished word loads if the buffer is empty or being drained on this same edge.
  assign accept = complete && (!valid_q || bus.out_ready);
  assign drop   = complete && valid_q && !bus.out_ready;

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      word_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (accept) begin
        word_q  <= complete_word;
        valid_q <= 1'b1;
      end else if (valid_q && bus.out_ready) begin
        valid_q <= 1'b0;
      end
      if (drop) begin
        overrun_q <= 1'b1;
      end else if (bus.overrun_clr) begin
        overrun_q <= 1'b0;
      end
    end
  end

`ifdef PARITY_CHECK_EN
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      perr_q <= 1'b0;
    end else if (accept) begin
      perr_q <= complete_perr;
    end
  end
  assign bus.parity_err = perr_q;
`else
  assign bus.parity_err = 1'b0;
`endif

  assign bus.word_out   = word_q;
  assign bus.word_valid = valid_q;
  assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_serial_deserializer.sv
// Scoreboard bench for serial_deserializer (WIDTH=4); stimulus pushes expected words, a
// negedge monitor pops them on each handshake. Parity cases run when PARITY_CHECK_EN is defined.
module tb_serial_deserializer;

  typedef struct packed {
    logic [3:0] word;
    logic       perr;
  } exp_t;

  logic clock = 1'b0;
  logic clear = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  serial_deserializer_if #(.WIDTH(4)) bus ();

  serial_deserializer #(.WIDTH(4)) dut (
    .clock(clock),
    .clear(clear),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_bit(input logic b);
    bus.bit_in    = b;
    bus.bit_valid = 1'b1;
    tick();
    bus.bit_valid = 1'b0;
    bus.bit_in    = 1'b0;
  endtask

  task automatic push_exp(input logic [3:0] w, input logic par);
    exp_t e;
    e.word = w;
`ifdef PARITY_CHECK_EN
    e.perr = ^{w, par};
`else
    e.perr = 1'b0 & par;
`endif
    sb.push_back(e);
  endtask

  // Start bit, 4 data bits MSB-first, optional stall after data bit gap_at, then parity bit.
  task automatic send_frame(input logic [3:0] w, input logic par, input bit keep,
                            input int gap_at, input int gap_len);
    if (keep) push_exp(w, par);
    send_bit(1'b1);
    for (int i = 0; i < 4; i++) begin
      send_bit(w[3-i]);
      if (i == gap_at) begin
        for (int g = 0; g < gap_len; g++) begin
          tick();
          check("gap_no_valid", bus.word_valid, 0);
        end
      end
    end
`ifdef PARITY_CHECK_EN
    send_bit(par);
`endif
  endtask

  always @(negedge clock) begin
    if (!clear && bus.word_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_word", bus.word_out, 32'hffff_ffff);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sb_word", bus.word_out, e.word);
        check("sb_parity_err", bus.parity_err, e.perr);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.bit_in      = 1'b0;
    bus.bit_valid   = 1'b0;
    bus.out_ready   = 1'b0;
    bus.overrun_clr = 1'b0;
    tick();
    tick();
    check("rst_word_out", bus.word_out, 0);
    check("rst_word_valid", bus.word_valid, 0);
    check("rst_overrun", bus.overrun, 0);
    check("rst_parity_err", bus.parity_err, 0);
    clear = 1'b0;
    tick();

    // 1: asynchronous clear with a word held, then a stream of zeros produces nothing
    send_frame(4'b1011, 1'b1, 1'b0, -1, 0);
    check("t1_loaded", bus.word_valid, 1);
    send_frame(4'b0110, 1'b0, 1'b0, -1, 0);
    check("t1_overrun_set", bus.overrun, 1);
    #2 clear = 1'b1;
    #1;
    check("t1_async_word_out", bus.word_out, 0);
    check("t1_async_word_valid", bus.word_valid, 0);
    check("t1_async_overrun", bus.overrun, 0);
    tick();
    clear = 1'b0;
    for (int i = 0; i < 6; i++) send_bit(1'b0);
    check("t1_zeros_no_valid", bus.word_valid, 0);

    // 2: basic frame, zero latency, consumed on the following edge
    bus.out_ready = 1'b1;
    send_frame(4'b1011, 1'b1, 1'b1, -1, 0);
    check("t2_valid_after_last", bus.word_valid, 1);
    check("t2_word_out", bus.word_out, 4'b1011);
    tick();
    check("t2_valid_cleared", bus.word_valid, 0);

    // 3: bit_valid low for 3 cycles mid-frame holds the frame
    send_frame(4'b1011, 1'b1, 1'b1, 1, 3);
    check("t3_valid", bus.word_valid, 1);
    tick();

    // 4: backpressure drops the second word and sets overrun
    bus.out_ready = 1'b0;
    send_frame(4'b1011, 1'b1, 1'b1, -1, 0);
    send_frame(4'b0110, 1'b0, 1'b0, -1, 0);
    check("t4_word_kept", bus.word_out, 4'b1011);
    check("t4_overrun", bus.overrun, 1);
    check("t4_valid_held", bus.word_valid, 1);
    bus.out_ready = 1'b1;
    tick();
    check("t4_drained", bus.word_valid, 0);
    check("t4_overrun_sticky", bus.overrun, 1);
    bus.overrun_clr = 1'b1;
    tick();
    bus.overrun_clr = 1'b0;
    check("t4_overrun_cleared", bus.overrun, 0);

    // 4b: overrun_clr on the same edge as a new drop leaves overrun set
    bus.out_ready = 1'b0;
    send_frame(4'b1001, 1'b0, 1'b1, -1, 0);
    bus.overrun_clr = 1'b1;
    send_frame(4'b0011, 1'b0, 1'b0, -1, 0);
    bus.overrun_clr = 1'b0;
    check("t4b_set_wins", bus.overrun, 1);
    bus.out_ready = 1'b1;
    tick();
    bus.overrun_clr = 1'b1;
    tick();
    bus.overrun_clr = 1'b0;

    // 5: clear mid-frame discards the partial frame
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    #2 clear = 1'b1;
    #2 clear = 1'b0;
    tick();
    send_frame(4'b0101, 1'b0, 1'b1, -1, 0);
    check("t5_word_out", bus.word_out, 4'b0101);
    tick();

    // back-to-back frames with no gap
    send_frame(4'b1100, 1'b0, 1'b1, -1, 0);
    send_frame(4'b0011, 1'b0, 1'b1, -1, 0);
    check("b2b_second_word", bus.word_out, 4'b0011);
    tick();

`ifdef PARITY_CHECK_EN
    // 6: even parity good and bad
    send_frame(4'b1011, 1'b1, 1'b1, -1, 0);
    check("t6_parity_ok", bus.parity_err, 0);
    tick();
    send_frame(4'b1011, 1'b0, 1'b1, -1, 0);
    check("t6_parity_bad", bus.parity_err, 1);
    check("t6_word_out", bus.word_out, 4'b1011);
    tick();
`endif

    tick();
    check("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
